// File: rtl/datapath.sv
// Single-bus 32-bit datapath slice: R1-R3, PC, MDR, Y and a 64-bit Z joined by one bus.
// The ALU does AND and PC increment; strobes come from an external control unit.
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  output logic [31:0] BusMuxOut,
  output logic [31:0] R1_q,
  output logic [31:0] R2_q,
  output logic [31:0] R3_q,
  output logic [31:0] PC_q,
  output logic [31:0] MDR_q,
  output logic [31:0] Y_q,
  output logic [31:0] Zlow_q,
  output logic [31:0] Zhigh_q
);

  localparam int unsigned W = 32;

  logic [2*W-1:0] alu_result;
  logic           z_in;
  logic           inc_pending_q;

  // Priority bus mux; never floats, reads zero with no driver.
  always_comb begin
    BusMuxOut = '0;
    if (Zlowout)     BusMuxOut = Zlow_q;
    else if (MDRout) BusMuxOut = MDR_q;
    else if (PCout)  BusMuxOut = PC_q;
    else if (R2out)  BusMuxOut = R2_q;
    else if (R3out)  BusMuxOut = R3_q;
  end

  always_comb begin
    alu_result = '0;
    if (PCout) alu_result = {W'(0), BusMuxOut + W'(1)};
    else       alu_result = {W'(0), Y_q & BusMuxOut};
  end

  assign z_in = (PCout | R2out | R3out) & ~Zlowout;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      R1_q          <= '0;
      R2_q          <= '0;
      R3_q          <= '0;
      PC_q          <= '0;
      MDR_q         <= '0;
      Y_q           <= '0;
      Zlow_q        <= '0;
      Zhigh_q       <= '0;
      inc_pending_q <= 1'b0;
    end else begin
      if (R1in) R1_q <= BusMuxOut;
      if (R2in) R2_q <= BusMuxOut;
      if (R3in) R3_q <= BusMuxOut;
      if (Yin)  Y_q  <= BusMuxOut;
      if (MDRin) MDR_q <= Read ? Mdatain : BusMuxOut;
      if (z_in) begin
        Zlow_q  <= alu_result[W-1:0];
        Zhigh_q <= alu_result[2*W-1:W];
      end
      // Only an increment result in Z may be written back into PC.
      if (Zlowout && inc_pending_q) PC_q <= Zlow_q;
      if (Zlowout)   inc_pending_q <= 1'b0;
      else if (z_in) inc_pending_q <= PCout;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: reset, loads, AND, fetch, bus priority, PC wrap, mid-sequence clear.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, MDRin, Yin, R1in, R2in, R3in;
  logic        PCout, Zlowout, MDRout, R2out, R3out;
  logic [31:0] BusMuxOut, R1_q, R2_q, R3_q, PC_q, MDR_q, Y_q, Zlow_q, Zhigh_q;

  int n_checks = 0;
  int n_errors = 0;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .MDRin(MDRin),
    .Yin(Yin), .R1in(R1in), .R2in(R2in), .R3in(R3in), .PCout(PCout),
    .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .BusMuxOut(BusMuxOut), .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .PC_q(PC_q),
    .MDR_q(MDR_q), .Y_q(Y_q), .Zlow_q(Zlow_q), .Zhigh_q(Zhigh_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic idle();
    Read = 0; MDRin = 0; Yin = 0; R1in = 0; R2in = 0; R3in = 0;
    PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0;
  endtask

  // Apply the strobes set by the caller across one rising edge, then drop them.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".R1"}, R1_q, 32'h0);
    check({tag, ".R2"}, R2_q, 32'h0);
    check({tag, ".R3"}, R3_q, 32'h0);
    check({tag, ".PC"}, PC_q, 32'h0);
    check({tag, ".MDR"}, MDR_q, 32'h0);
    check({tag, ".Y"}, Y_q, 32'h0);
    check({tag, ".Zlow"}, Zlow_q, 32'h0);
    check({tag, ".Zhigh"}, Zhigh_q, 32'h0);
  endtask

  task automatic load_via_mdr(input logic [31:0] val, input int dst, input string tag);
    Mdatain = val; Read = 1; MDRin = 1;
    tick();
    check({tag, ".mdr"}, MDR_q, val);
    MDRout = 1;
    R1in = (dst == 1); R2in = (dst == 2); R3in = (dst == 3); Yin = (dst == 0);
    #1;
    check({tag, ".bus"}, BusMuxOut, val);
    tick();
  endtask

  initial begin
    idle();
    clear = 1'b0;
    Mdatain = 32'hDEADBEEF;
    // Random strobes while held in reset must not load anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      {Read, MDRin, Yin, R1in, R2in, R3in} = 6'($urandom);
      {PCout, Zlowout, MDRout, R2out, R3out} = 5'($urandom);
    end
    @(negedge clock);
    check_all_zero("in_reset");
    idle();
    clear = 1'b1;
    #1;
    check_all_zero("reset");
    check("reset.bus", BusMuxOut, 32'h0);

    load_via_mdr(32'h12, 2, "ld_r2");
    check("ld_r2.r2", R2_q, 32'h12);
    load_via_mdr(32'h14, 3, "ld_r3");
    check("ld_r3.r3", R3_q, 32'h14);
    load_via_mdr(32'h18, 1, "ld_r1");
    check("ld_r1.r1", R1_q, 32'h18);

    // and R1, R2, R3
    R2out = 1; Yin = 1; tick();
    check("and.y", Y_q, 32'h12);
    R3out = 1; tick();
    check("and.zlow", Zlow_q, 32'h10);
    check("and.zhigh", Zhigh_q, 32'h0);
    Zlowout = 1; R1in = 1; #1;
    check("and.bus", BusMuxOut, 32'h10);
    tick();
    check("and.r1", R1_q, 32'h10);
    check("and.r2", R2_q, 32'h12);
    check("and.r3", R3_q, 32'h14);
    check("and.pc_hold", PC_q, 32'h0);

    // Two instruction fetches
    PCout = 1; tick();
    check("f1.zlow", Zlow_q, 32'h1);
    Zlowout = 1; Read = 1; MDRin = 1; Mdatain = 32'h2; tick();
    check("f1.pc", PC_q, 32'h1);
    check("f1.mdr", MDR_q, 32'h2);
    PCout = 1; tick();
    check("f2.zlow", Zlow_q, 32'h2);
    Zlowout = 1; Read = 1; MDRin = 1; Mdatain = 32'h3; tick();
    check("f2.pc", PC_q, 32'h2);
    check("f2.mdr", MDR_q, 32'h3);

    // Bus priority: Zlow beats MDR and R2, and Z does not reload
    load_via_mdr(32'h10, 0, "ld_y");
    check("ld_y.y", Y_q, 32'h10);
    PCout = 1; tick();
    check("prio.zpre", Zlow_q, 32'h3);
    Zlowout = 1; MDRout = 1; R2out = 1; #1;
    check("prio.bus_zlow", BusMuxOut, 32'h3);
    tick();
    check("prio.z_hold", Zlow_q, 32'h3);
    check("prio.pc", PC_q, 32'h3);
    R2out = 1; R3out = 1; #1;
    check("prio.bus_r2", BusMuxOut, 32'h12);
    idle();
    #1;
    check("prio.bus_idle", BusMuxOut, 32'h0);

    // PC wrap: inject 0xFFFFFFFE via MDR, increment twice
    Mdatain = 32'hFFFF_FFFE; Read = 1; MDRin = 1; tick();
    PCout = 1; MDRout = 1; #1;
    check("wrap.bus", BusMuxOut, 32'hFFFF_FFFE);
    tick();
    check("wrap.z1", Zlow_q, 32'hFFFF_FFFF);
    Zlowout = 1; tick();
    check("wrap.pc1", PC_q, 32'hFFFF_FFFF);
    PCout = 1; tick();
    check("wrap.z2", Zlow_q, 32'h0);
    check("wrap.zhigh", Zhigh_q, 32'h0);
    Zlowout = 1; tick();
    check("wrap.pc2", PC_q, 32'h0);

    // Clear between AND steps 2 and 3
    R2out = 1; Yin = 1; tick();
    R3out = 1; tick();
    check("abort.zpre", Zlow_q, 32'h10);
    clear = 1'b0;
    #1;
    check_all_zero("abort.async");
    Zlowout = 1; R1in = 1; tick();
    check("abort.r1_in_reset", R1_q, 32'h0);
    clear = 1'b1;
    tick();
    check("abort.r1", R1_q, 32'h0);
    check("abort.zlow", Zlow_q, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/datapath.md
# datapath

Single-bus 32-bit processor datapath slice. It holds general registers R1–R3, a PC, an MDR, an ALU input latch Y and a 64-bit ALU result register Z (Zhigh/Zlow), all joined by one shared 32-bit bus. An external control unit or bench drives one-hot register-out/register-in strobes each clock. The ALU supports AND and PC increment, which is enough to execute `and R1, R2, R3` and an instruction-fetch PC update.

## Interface
Parameters: none (data width fixed at 32).
- clock  in  1  rising-edge clock for all state
- clear  in  1  asynchronous, active-low reset; 0 forces every register to 0
- Mdatain  in  32  memory read data
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus
- MDRin  in  1  load MDR
- Yin  in  1  load Y from bus
- R1in, R2in, R3in  in  1 each  load R1/R2/R3 from bus
- PCout, Zlowout, MDRout, R2out, R3out  in  1 each  drive PC/Zlow/MDR/R2/R3 onto bus
- BusMuxOut  out  32  current bus value
- R1_q, R2_q, R3_q, PC_q, MDR_q, Y_q  out  32 each  register contents
- Zlow_q, Zhigh_q  out  32 each  Z[31:0], Z[63:32]

## Operation
- Bus is combinational. Driver priority: Zlowout > MDRout > PCout > R2out > R3out. When no driver is asserted, the bus is 32'h0.
- MDR: when MDRin=1, MDR <= Read ? Mdatain : bus.
- R1/R2/R3/Y: load bus when the matching *in strobe is 1; otherwise hold. One bus value may load several registers in the same cycle.
- ALU is combinational.
  - If PCout=1: result = {32'h0, bus + 1}, a 32-bit increment that wraps 32'hFFFFFFFF to 0.
  - Otherwise: result = {32'h0, Y & bus}.
  - Zhigh is therefore always 0 for the current operation set.
- Z write enable (internal): Zin = (PCout | R2out | R3out) & ~Zlowout. Z <= result when Zin=1.
- Internal flag inc_pending:
  - Set on any edge where Zin=1 and PCout=1.
  - Cleared on any other edge where Zin=1.
  - Cleared on any edge where Zlowout=1.
- PC update: on an edge where Zlowout=1 and inc_pending=1, PC <= Zlow. PC has no other load path.
- There is no IR or memory address register in this block. Instruction decode is external.
- Undefined multi-driver combinations resolve by the bus priority above. No X is ever placed on the bus.

## Timing
- All registers update on the rising edge of clock. Strobes and Mdatain are sampled at that edge.
- clear=0 immediately, without waiting for a clock, sets PC, R1–R3, MDR, Y, Z and inc_pending to 0. All *_q outputs read 0 while clear=0, and loads are ignored.
- After clear returns to 1, the next rising edge is the first functional edge.
- Latency:
  - Register load: value appears on *_q one edge after the strobe.
  - Bus: follows strobes combinationally, same cycle.
- AND sequence, one edge per step:
  1. R2out+Yin
  2. R3out (Z computes Y & R3)
  3. Zlowout+R1in
  - R1 holds the result after the third edge.
- Fetch sequence:
  1. PCout (Z = PC+1)
  2. Zlowout+Read+MDRin (PC <= PC+1, MDR <= Mdatain)
- clear asserted mid-sequence aborts it. State restarts from all-zero and no partial writes persist.

## Test plan
- Reset: drive clear=0 with random strobes, then release → every *_q = 0 and BusMuxOut = 0 with no strobes active.
- Register load: Mdatain=0x12, Read+MDRin, then MDRout+R2in → R2_q=0x12. Repeat with 0x14 → R3, and with 0x18 → R1. BusMuxOut equals MDR during each MDRout cycle.
- AND: with R2=0x12, R3=0x14, run R2out+Yin, then R3out, then Zlowout+R1in → Y_q=0x12, Zlow_q=0x10, Zhigh_q=0, R1_q=0x10. R2 and R3 are unchanged.
- Fetch: from PC=0, run PCout, then Zlowout+Read+MDRin with Mdatain=0x2 → Zlow=1, PC_q=1, MDR_q=0x2. A second fetch gives PC_q=2. From PC=0xFFFFFFFF, a fetch wraps PC to 0.
- Bus priority: assert Zlowout+MDRout+R2out together → BusMuxOut=Zlow, and Z does not load. R2out+R3out together → BusMuxOut=R2.
- Zlowout after an AND (inc_pending=0) → PC unchanged. Asserting clear=0 between AND steps 2 and 3 → R1 stays 0 and Z=0.
